// File: rtl/dec_func_pkg.sv
// Shared definitions for the pipelined decoder / function block.
// Contents:
//   - legacy 3-to-8 minterm tables and the default reset truth-table image
//   - width helpers for the decode vector and the config index port
//   - onehot_to_idx: converts a one-hot minterm vector back to its index
package dec_func_pkg;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_M     = 64;

    // Legacy fixed functions of a 3-bit select, bit m = output for select m.
    localparam logic [7:0] LEGACY_F1 = 8'h94;  // sum(2,4,7)
    localparam logic [7:0] LEGACY_F2 = 8'h09;  // sum(0,3)
    localparam logic [7:0] LEGACY_F3 = 8'h9D;  // not sum(1,5,6)

    localparam logic [23:0] F_INIT_DEFAULT = {LEGACY_F3, LEGACY_F2, LEGACY_F1};

    function automatic int unsigned minterm_count(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    function automatic int unsigned cfg_idx_width(input int unsigned num_f);
        return (num_f > 1) ? $clog2(num_f) : 1;
    endfunction

    // Index of the set bit; an all-zero vector maps to 0.
    function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_M-1:0] oh);
        logic [MAX_SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_M; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dec_func_tt_bank.sv
// Truth-table bank: NUM_F run-time writable tables of M bits each, plus the
// per-function lookup for a one-hot minterm select.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (tables return to F_INIT)
//   we, widx     write strobe and table index; out-of-range indices are ignored
//   wdata        new truth table
//   sel_oh       one-hot minterm select
//   f            looked-up function values, bit k = table k
module dec_func_tt_bank
    import dec_func_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned NUM_F = 3,
    parameter logic [NUM_F*minterm_count(SEL_W)-1:0] F_INIT = F_INIT_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [cfg_idx_width(NUM_F)-1:0]     widx,
    input  logic [minterm_count(SEL_W)-1:0]     wdata,
    input  logic [minterm_count(SEL_W)-1:0]     sel_oh,
    output logic [NUM_F-1:0]                    f
);

    localparam int unsigned M     = minterm_count(SEL_W);
    localparam int unsigned IDX_W = cfg_idx_width(NUM_F);

    logic [NUM_F-1:0][M-1:0] tt_q;
    logic [SEL_W-1:0]        sel_idx;

    // Matching against each legal index drops writes to nonexistent tables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q <= F_INIT;
        end else if (we) begin
            for (int k = 0; k < NUM_F; k++) begin
                if (widx == IDX_W'(k)) begin
                    tt_q[k] <= wdata;
                end
            end
        end
    end

    always_comb begin
        sel_idx = SEL_W'(onehot_to_idx(MAX_M'(sel_oh)));
        f = '0;
        for (int k = 0; k < NUM_F; k++) begin
            f[k] = tt_q[k][sel_idx];
        end
    end

endmodule

// File: rtl/dec_func_pipe.sv
// Two-stage pipelined select decoder with NUM_F table-driven Boolean functions
// and saturating per-function hit counters.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready/in_sel  select input handshake
//   out_valid/out_ready       result handshake; out_dec one-hot, out_f functions
//   cfg_we/cfg_idx/cfg_tt     truth-table write port, no handshake
//   cnt_clr                   synchronous clear of all hit counters
//   cnt                       hit counters, function k at [k*CNT_W +: CNT_W]
module dec_func_pipe
    import dec_func_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned NUM_F = 3,
    parameter int unsigned CNT_W = 16,
    parameter logic [NUM_F*minterm_count(SEL_W)-1:0] F_INIT = F_INIT_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SEL_W-1:0]                    in_sel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [minterm_count(SEL_W)-1:0]     out_dec,
    output logic [NUM_F-1:0]                    out_f,
    input  logic                                cfg_we,
    input  logic [cfg_idx_width(NUM_F)-1:0]     cfg_idx,
    input  logic [minterm_count(SEL_W)-1:0]     cfg_tt,
    input  logic                                cnt_clr,
    output logic [NUM_F*CNT_W-1:0]              cnt
);

    localparam int unsigned M = minterm_count(SEL_W);

    logic                          s1_valid_q;
    logic [M-1:0]                  s1_dec_q;
    logic                          out_valid_q;
    logic [M-1:0]                  out_dec_q;
    logic [NUM_F-1:0]              out_f_q;
    logic [NUM_F-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_F-1:0]              tt_f;
    logic                          s1_advance;
    logic                          in_fire;
    logic                          out_fire;

    // Lookup runs on the current table contents, so a same-edge write only
    // affects later advances.
    dec_func_tt_bank #(
        .SEL_W  (SEL_W),
        .NUM_F  (NUM_F),
        .F_INIT (F_INIT)
    ) u_tt_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_we),
        .widx   (cfg_idx),
        .wdata  (cfg_tt),
        .sel_oh (s1_dec_q),
        .f      (tt_f)
    );

    always_comb begin
        s1_advance = s1_valid_q & (~out_valid_q | out_ready);
        in_ready   = ~s1_valid_q | s1_advance;
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid_q & out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_dec_q    <= '0;
            out_valid_q <= 1'b0;
            out_dec_q   <= '0;
            out_f_q     <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_dec_q   <= M'(1) << in_sel;
            end else if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_advance) begin
                out_valid_q <= 1'b1;
                out_dec_q   <= s1_dec_q;
                out_f_q     <= tt_f;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire) begin
            for (int k = 0; k < NUM_F; k++) begin
                if (out_f_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dec   = out_dec_q;
    assign out_f     = out_f_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_dec_func_pipe.sv
// Self-checking bench for dec_func_pipe (SEL_W=3, NUM_F=3, CNT_W=4).
// A queue-based model predicts every output each cycle; directed literal
// checks pin the default functions, stall behaviour, table race and reset.
module tb_dec_func_pipe;
    import dec_func_pkg::*;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned NUM_F = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned M     = 8;
    localparam int          CMAX  = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [M-1:0]      out_dec;
    logic [NUM_F-1:0]  out_f;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_idx = '0;
    logic [M-1:0]      cfg_tt = '0;
    logic              cnt_clr = 1'b0;
    logic [NUM_F*CNT_W-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    dec_func_pipe #(
        .SEL_W (SEL_W),
        .NUM_F (NUM_F),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .out_f     (out_f),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_tt    (cfg_tt),
        .cnt_clr   (cnt_clr),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Items in flight, oldest first. An item is "done" once it holds its result
    // in the output stage; at most one done and one pending item exist.
    typedef struct {
        int              sel;
        logic [NUM_F-1:0] f;
        bit              done;
    } item_t;

    item_t      flight[$];
    logic [M-1:0] tt_m[NUM_F];
    int         cnt_m[NUM_F];

    function automatic bit m_has_out();
        return (flight.size() > 0) && flight[0].done;
    endfunction

    function automatic bit m_has_s1();
        return (flight.size() > 0) && !flight[flight.size()-1].done;
    endfunction

    function automatic bit m_in_ready();
        return !m_has_s1() || (!m_has_out() || out_ready);
    endfunction

    task automatic model_reset();
        flight.delete();
        tt_m[0] = LEGACY_F1;
        tt_m[1] = LEGACY_F2;
        tt_m[2] = LEGACY_F3;
        for (int k = 0; k < NUM_F; k++) cnt_m[k] = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            bit has_out, has_s1, fire_out, adv, acc;
            has_out  = m_has_out();
            has_s1   = m_has_s1();
            fire_out = has_out && out_ready;
            adv      = has_s1 && (!has_out || out_ready);
            acc      = in_valid && (!has_s1 || adv);
            if (cnt_clr) begin
                for (int k = 0; k < NUM_F; k++) cnt_m[k] = 0;
            end else if (fire_out) begin
                for (int k = 0; k < NUM_F; k++)
                    if (flight[0].f[k] && cnt_m[k] < CMAX) cnt_m[k]++;
            end
            if (adv) begin
                item_t it;
                int    idx;
                it  = flight[flight.size()-1];
                idx = int'(onehot_to_idx(64'(1) << it.sel));
                for (int k = 0; k < NUM_F; k++) it.f[k] = tt_m[k][idx];
                it.done = 1'b1;
                flight[flight.size()-1] = it;
            end
            if (fire_out) void'(flight.pop_front());
            if (acc) begin
                item_t nw;
                nw.sel  = int'(in_sel);
                nw.f    = '0;
                nw.done = 1'b0;
                flight.push_back(nw);
            end
            if (cfg_we && cfg_idx < 2'(NUM_F)) tt_m[cfg_idx] = cfg_tt;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
            chk("out_valid", 64'(out_valid), 64'(m_has_out()));
            if (m_has_out()) begin
                chk("out_dec", 64'(out_dec), 64'(1) << flight[0].sel);
                chk("out_f", 64'(out_f), 64'(flight[0].f));
            end
            for (int k = 0; k < NUM_F; k++)
                chk($sformatf("cnt%0d", k), 64'(cnt[k*CNT_W +: CNT_W]), 64'(cnt_m[k]));
        end
    end

    // Captured output transfers as {dec, f}.
    logic [M+NUM_F-1:0] got[$];
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back({out_dec, out_f});
    end

    // ---------------- directed stimulus ----------------
    logic [NUM_F-1:0] def_f[M];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_all();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = SEL_W'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_defaults(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk($sformatf("%s_dec%0d", tag, i), 64'(got[i][M+NUM_F-1:NUM_F]), 64'(1) << i);
            chk($sformatf("%s_f%0d", tag, i), 64'(got[i][NUM_F-1:0]), 64'(def_f[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        def_f[0] = 3'b110; def_f[1] = 3'b000; def_f[2] = 3'b101; def_f[3] = 3'b110;
        def_f[4] = 3'b101; def_f[5] = 3'b000; def_f[6] = 3'b000; def_f[7] = 3'b101;
        model_reset();

        repeat (2) tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_dec", 64'(out_dec), 64'd0);
        chk("rst_out_f", 64'(out_f), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);

        // Default tables, full throughput.
        out_ready = 1'b1;
        got.delete();
        stream_all();
        check_defaults("dflt");

        // Stall: only two selects fit while the output is blocked.
        got.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 3'd2; tick();
        in_sel = 3'd5; tick();
        in_sel = 3'd6;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (3) tick();
        chk("stall_hold_dec", 64'(out_dec), 64'h04);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("stall_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("stall_order0", 64'(got[0][M+NUM_F-1:NUM_F]), 64'h04);
            chk("stall_order1", 64'(got[1][M+NUM_F-1:NUM_F]), 64'h20);
            chk("stall_order2", 64'(got[2][M+NUM_F-1:NUM_F]), 64'h40);
        end

        // Table write racing an advance uses the old table.
        in_valid = 1'b1; in_sel = 3'd1; tick();
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_tt = 8'hFF; tick();
        cfg_we = 1'b0;
        chk("race_valid", 64'(out_valid), 64'd1);
        chk("race_old_tt", 64'(out_f[0]), 64'd0);
        in_valid = 1'b1; in_sel = 3'd1; tick();
        in_valid = 1'b0; tick();
        chk("race_new_valid", 64'(out_valid), 64'd1);
        chk("race_new_tt", 64'(out_f[0]), 64'd1);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_tt = 8'h94; tick();
        cfg_we = 1'b0; tick();

        // Out-of-range index must not touch any table.
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_tt = 8'hFF; tick();
        cfg_we = 1'b0;
        got.delete();
        stream_all();
        check_defaults("badidx");

        // Saturating counters.
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", 64'(cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_sel = 3'd7; tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("sat_cnt0", 64'(cnt[0 +: 4]), 64'd15);
        chk("sat_cnt1", 64'(cnt[4 +: 4]), 64'd0);
        chk("sat_cnt2", 64'(cnt[8 +: 4]), 64'd15);
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        in_valid = 1'b1; in_sel = 3'd7; tick();
        in_valid = 1'b0; tick();
        chk("clr_race_pre_valid", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        chk("clr_race_cnt", 64'(cnt), 64'd0);

        // Async reset mid-stream with counters, table and both stages dirty.
        in_valid = 1'b1; in_sel = 3'd7; tick();
        in_valid = 1'b0; tick(); tick();
        chk("pre_rst_cnt0", 64'(cnt[0 +: 4]), 64'd1);
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_tt = 8'h00; tick();
        cfg_we = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 3'd3; tick();
        in_sel = 3'd4; tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_s1_empty", 64'(in_ready), 64'd1);
        chk("arst_cnt", 64'(cnt), 64'd0);
        chk("arst_out_f", 64'(out_f), 64'd0);
        tick();
        rst = 1'b0;
        got.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_sel = 3'd4; tick();
        in_valid = 1'b0; tick(); tick();
        chk("arst_tt_count", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("arst_tt_f", 64'(got[0][NUM_F-1:0]), 64'b101);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
